// File: rtl/disp_pkg.sv
// Shared glyph constants and nibble-to-segment encoding for the 7-segment scanner.
// Segment order is ABCDEFG with A in bit 6; all glyphs are active-low.
package disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'b0000001;
    localparam logic [6:0] SEG_1 = 7'b1001111;
    localparam logic [6:0] SEG_2 = 7'b0010010;
    localparam logic [6:0] SEG_3 = 7'b0000110;
    localparam logic [6:0] SEG_4 = 7'b1001100;
    localparam logic [6:0] SEG_5 = 7'b0100100;
    localparam logic [6:0] SEG_6 = 7'b0100000;
    localparam logic [6:0] SEG_7 = 7'b0001111;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0000100;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b1100000;
    localparam logic [6:0] SEG_C = 7'b0110001;
    localparam logic [6:0] SEG_D = 7'b1000010;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_F = 7'b0111000;

    // Codes 10-15 render as letters only in hex mode; in decimal mode they go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] nibble, input logic hex_mode);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = hex_mode ? SEG_A : SEG_BLANK;
            4'hB:    seg = hex_mode ? SEG_B : SEG_BLANK;
            4'hC:    seg = hex_mode ? SEG_C : SEG_BLANK;
            4'hD:    seg = hex_mode ? SEG_D : SEG_BLANK;
            4'hE:    seg = hex_mode ? SEG_E : SEG_BLANK;
            default: seg = hex_mode ? SEG_F : SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_encode_7.sv
// Combinational nibble-to-glyph encoder; thin wrapper so the lookup can be
// instantiated wherever a segment bus is driven.
module seg_encode_7
    import disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg
);

    always_comb begin
        seg = seg_encode(nibble, hex_mode);
    end

endmodule

// File: rtl/disp_7seg_scan.sv
// Time-multiplexed driver for N common-anode 7-segment digits on one shared bus.
// Display data is double-buffered and only committed at frame boundaries.
module disp_7seg_scan
    import disp_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DWELL    = 50000,
    parameter int BLANK    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] data_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [N_DIGITS-1:0]   an_n,
    output logic                  frame_done
);

    localparam int PW = $clog2(DWELL);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DWELL - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [4*N_DIGITS-1:0]   pend_data;
    logic [N_DIGITS-1:0]     pend_dp;
    logic                    pend_valid;
    logic [4*N_DIGITS-1:0]   disp_data;
    logic [N_DIGITS-1:0]     disp_dp;

    logic                    wrap;
    logic                    boundary;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_lz;
    logic                    zero_above;
    logic [N_DIGITS-1:0]     an_next;
    logic [6:0]              glyph;
    logic [6:0]              seg_next;

    assign wrap     = en && (presc == PRESC_LAST);
    assign boundary = wrap && (idx == IDX_LAST);

    // Walk from the most significant digit down so zero_above tracks whether
    // every nibble from k upward is zero when digit k is reached.
    always_comb begin
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        zero_above = 1'b1;
        an_next    = '1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_data[4*k +: 4] == 4'h0);
            if (idx == IW'(k)) begin
                cur_nib = disp_data[4*k +: 4];
                cur_dp  = disp_dp[k];
                cur_lz  = zero_above && (k != 0);
                if (presc >= BLANK_END) begin
                    an_next[k] = 1'b0;
                end
            end
        end
    end

    seg_encode_7 u_seg_encode (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .seg      (glyph)
    );

    assign seg_next = (lz_blank && cur_lz) ? SEG_BLANK : glyph;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (en) begin
            presc <= wrap ? '0 : presc + PW'(1);
            if (wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
            end
        end
    end

    // A load coinciding with a boundary still refills pending after the old
    // pending contents have moved to the display.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp_data  <= '0;
            disp_dp    <= '0;
        end else begin
            if (boundary && pend_valid) begin
                disp_data <= pend_data;
                disp_dp   <= pend_dp;
            end
            if (load) begin
                pend_data  <= data_in;
                pend_dp    <= dp_in;
                pend_valid <= 1'b1;
            end else if (boundary) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (en) begin
                seg_n <= seg_next;
                dp_n  <= ~cur_dp;
                an_n  <= an_next;
            end else begin
                seg_n <= SEG_BLANK;
                dp_n  <= 1'b1;
                an_n  <= '1;
            end
        end
    end

endmodule
